// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: a free-running 10-bit LFSR is compared
// against a difficulty threshold on each decision tick to produce press pulses.
module cpu_player #(
  parameter logic [9:0] SEED     = 10'h001,
  parameter int         TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [9:0] difficulty,
  output logic       press,
  output logic [9:0] lfsr,
  output logic [1:0] fsm_state
);

  localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST     = CW'(TICK_DIV - 1);
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [9:0]     SEED_OK  = (SEED == 10'h000) ? 10'h001 : SEED;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_PRESS = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          tick;
  logic          hit;

  assign tick      = (count == LAST);
  assign hit       = tick & enable & (difficulty > lfsr);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // x^10 + x^7 + 1, advancing on every tick independent of the FSM.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      lfsr <= SEED_OK;
    end else if (tick) begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  // COOL holds off the next decision until a tick has passed, so pulses never abut.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_WAIT;
      press <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (hit) begin
            state <= ST_PRESS;
            press <= 1'b1;
          end else begin
            press <= 1'b0;
          end
        end
        ST_PRESS: begin
          state <= ST_COOL;
          press <= 1'b0;
        end
        ST_COOL: begin
          press <= 1'b0;
          if (tick) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          state <= ST_WAIT;
          press <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_player.sv
// Bench for cpu_player: three instances (TICK_DIV 1, TICK_DIV 4, SEED 0) checked
// cycle by cycle against a reference model, plus direct pattern and corner checks.
module tb_cpu_player;

  localparam int W = 33;

  logic       clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic [9:0] difficulty;
  logic       press1, press4, press0;
  logic [9:0] lfsr1, lfsr4, lfsr0;
  logic [1:0] st1, st4, st0;

  always #5 clk = ~clk;

  cpu_player #(.SEED(10'h001), .TICK_DIV(1)) u1 (
    .clk(clk), .Reset(Reset), .enable(enable), .difficulty(difficulty),
    .press(press1), .lfsr(lfsr1), .fsm_state(st1)
  );
  cpu_player #(.SEED(10'h001), .TICK_DIV(4)) u4 (
    .clk(clk), .Reset(Reset), .enable(enable), .difficulty(difficulty),
    .press(press4), .lfsr(lfsr4), .fsm_state(st4)
  );
  cpu_player #(.SEED(10'h000), .TICK_DIV(1)) u0 (
    .clk(clk), .Reset(Reset), .enable(enable), .difficulty(difficulty),
    .press(press0), .lfsr(lfsr0), .fsm_state(st0)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state, index 0 = u1, 1 = u4, 2 = u0.
  logic [9:0] m_lfsr[3];
  int         m_cnt[3];
  int         m_st[3];
  int         m_div[3] = '{1, 4, 1};

  int         e;
  logic       prev_p1, prev_p4;
  logic [9:0] prev_l1, prev_l4;
  int         last_rise4;
  int         rises1, rises4, tot_rises4;
  int         v_consec1 = 0, v_consec4 = 0, v_space4 = 0, v_lfsr4 = 0, v_3ff = 0;
  int         zero_seen = 0;

  typedef struct {
    logic       en;
    logic [9:0] diff;
    int         cycles;
    logic       expect_none;
  } vec_t;

  vec_t       tbl[4];
  int         cnt[4];
  logic [9:0] seq[7] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
  int         early_ret;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_lfsr[i] = 10'h001;
      m_cnt[i]  = 0;
      m_st[i]   = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic tk;
    for (int i = 0; i < 3; i++) begin
      tk = (m_cnt[i] == m_div[i] - 1);
      case (m_st[i])
        0:       if (tk && enable && (difficulty > m_lfsr[i])) m_st[i] = 1;
        1:       m_st[i] = 2;
        default: if (tk) m_st[i] = 0;
      endcase
      if (tk) begin
        m_lfsr[i] = lfsr_next(m_lfsr[i]);
        m_cnt[i]  = 0;
      end else begin
        m_cnt[i]++;
      end
    end
    exp_q.push_back({(m_st[0] == 1), m_lfsr[0], (m_st[1] == 1), m_lfsr[1],
                     (m_st[2] == 1), m_lfsr[2]});
  endtask

  task automatic step();
    logic [W-1:0] exp_v, act_v;
    prev_p1 = press1;
    prev_p4 = press4;
    prev_l1 = lfsr1;
    prev_l4 = lfsr4;
    @(posedge clk);
    model_step();
    #1;
    act_v = {press1, lfsr1, press4, lfsr4, press0, lfsr0};
    exp_v = exp_q.pop_front();
    check("cycle", act_v, exp_v);
    if (press1 && prev_p1) v_consec1++;
    if (press4 && prev_p4) v_consec4++;
    if (press1 && (prev_l1 == 10'h3FF)) v_3ff++;
    if ((lfsr1 == 10'h000) || (lfsr4 == 10'h000)) zero_seen++;
    if ((lfsr4 != prev_l4) != ((e % 4) == 3)) v_lfsr4++;
    if (press1 && !prev_p1) rises1++;
    if (press4 && !prev_p4) begin
      rises4++;
      tot_rises4++;
      if ((last_rise4 >= 0) && ((((e - last_rise4) % 4) != 0) || ((e - last_rise4) < 8)))
        v_space4++;
      last_rise4 = e;
    end
    e++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b0;
    model_reset();
    #1;
    check("reset_press_lfsr", W'({press1, lfsr1, press4, lfsr4, press0, lfsr0}),
          W'({1'b0, 10'h001, 1'b0, 10'h001, 1'b0, 10'h001}));
    check("reset_fsm", W'({st1, st4, st0}), W'(6'b0));
    check("seed0_lfsr", W'(lfsr0), W'(10'h001));
    @(negedge clk);
    Reset      = 1'b1;
    e          = 0;
    last_rise4 = -1;
    rises1     = 0;
    rises4     = 0;
  endtask

  initial begin
    Reset      = 1'b0;
    enable     = 1'b0;
    difficulty = 10'h000;
    tot_rises4 = 0;

    tbl[0] = '{1'b1, 10'h3FF, 3069, 1'b0};
    tbl[1] = '{1'b1, 10'd200, 3069, 1'b0};
    tbl[2] = '{1'b1, 10'h000, 2046, 1'b1};
    tbl[3] = '{1'b0, 10'h3FF, 300,  1'b1};

    // Free run with enable low: known sequence, period 1023, no presses.
    do_reset();
    difficulty = 10'h3FF;
    early_ret  = 0;
    for (int k = 0; k < 1023; k++) begin
      step();
      if (k < 7) check("lfsr_seq", W'(lfsr1), W'(seq[k]));
      if ((k < 1022) && (lfsr1 == 10'h001)) early_ret++;
    end
    check("lfsr_period", W'(lfsr1), W'(10'h001));
    check("lfsr_early_return", W'(early_ret), W'(0));
    check("free_run_no_press", W'(rises1 + rises4), W'(0));

    for (int r = 0; r < 4; r++) begin
      do_reset();
      enable     = tbl[r].en;
      difficulty = tbl[r].diff;
      for (int k = 0; k < tbl[r].cycles; k++) begin
        step();
        if ((r == 0) && (k < 12)) check("max_diff_pattern", W'(press1), W'((k % 3) == 0));
      end
      cnt[r] = rises1;
      if (tbl[r].expect_none) check("no_press", W'(rises1 + rises4), W'(0));
    end
    check("diff200_nonzero", W'(cnt[1] > 0), W'(1'b1));
    check("diff200_below_max", W'(cnt[1] < cnt[0]), W'(1'b1));
    check("td4_presses_seen", W'(tot_rises4 > 0), W'(1'b1));

    // Enable dropped while the pulse is high.
    do_reset();
    enable     = 1'b1;
    difficulty = 10'h3FF;
    step();
    check("drop_en_press_high", W'(press1), W'(1'b1));
    enable = 1'b0;
    step();
    check("drop_en_pulse_width", W'(press1), W'(1'b0));
    for (int k = 0; k < 20; k++) step();
    check("drop_en_no_more", W'(rises1), W'(1));

    // Reset asserted mid-cycle while press is high.
    do_reset();
    enable     = 1'b1;
    difficulty = 10'h3FF;
    step();
    check("pre_reset_press", W'(press1), W'(1'b1));
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_press", W'(press1), W'(1'b0));
    check("async_reset_lfsr", W'(lfsr1), W'(10'h001));
    check("async_reset_fsm", W'(st1), W'(2'd0));
    do_reset();
    for (int k = 0; k < 6; k++) step();

    check("no_consecutive_td1", W'(v_consec1), W'(0));
    check("no_consecutive_td4", W'(v_consec4), W'(0));
    check("td4_rise_spacing", W'(v_space4), W'(0));
    check("td4_lfsr_every_4th", W'(v_lfsr4), W'(0));
    check("no_hit_at_3ff", W'(v_3ff), W'(0));
    check("lfsr_never_zero", W'(zero_seen), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
